// File: rtl/hwpe_ctrl_package.sv
// Shared HWPE control types: job-context states and queue status flags.
// The context queue and register file agree on these encodings.
package hwpe_ctrl_package;

   localparam int REGFILE_N_CONTEXT = 4;
   localparam int REGFILE_CTX_W     = $clog2(REGFILE_N_CONTEXT);

   typedef enum logic [1:0] {
      CTX_FREE      = 2'd0,
      CTX_ACQUIRED  = 2'd1,
      CTX_COMMITTED = 2'd2,
      CTX_RUNNING   = 2'd3
   } ctx_state_e;

   typedef struct packed {
      logic [REGFILE_CTX_W-1:0] pointer_ctx;
      logic [REGFILE_CTX_W-1:0] running_ctx;
      logic                     is_working;
      logic                     status;
   } ctx_queue_flags_t;

endpackage

// File: rtl/hwpe_ctrl_ctx_queue.sv
// Job-context ring: cores acquire and commit contexts in order,
// the engine consumes them one at a time and signals completion.
module hwpe_ctrl_ctx_queue
   import hwpe_ctrl_package::*;
#(
   parameter int N_CONTEXT = 4,
   parameter int N_CORES   = 16,
   parameter int ID_WIDTH  = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic                         clear_i,
   input  logic                         acquire_req_i,
   input  logic [$clog2(N_CORES)-1:0]   acquire_core_i,
   output logic                         acquire_busy_o,
   output logic [ID_WIDTH-1:0]          acquire_id_o,
   input  logic                         commit_i,
   output logic                         start_o,
   input  logic                         done_i,
   output logic [N_CORES-1:0]           evt_o,
   output logic [$clog2(N_CONTEXT)-1:0] pointer_ctx_o,
   output logic [$clog2(N_CONTEXT)-1:0] running_ctx_o,
   output logic                         is_working_o,
   output logic                         status_o,
   output logic [ID_WIDTH-1:0]          nb_finished_o
);

   localparam int PW = $clog2(N_CONTEXT);
   localparam int CW = $clog2(N_CORES);

   ctx_state_e          state_q [N_CONTEXT];
   logic [CW-1:0]       owner_q [N_CONTEXT];
   logic [PW-1:0]       pointer_q;
   logic [PW-1:0]       running_q;
   logic [ID_WIDTH-1:0] id_q;
   logic [ID_WIDTH-1:0] nb_finished_q;
   logic                is_working_q;
   logic                start_q;
   logic [N_CORES-1:0]  evt_q;

   logic any_acq;
   logic any_used;
   logic grant;
   logic commit_ok;
   logic start_ok;
   logic done_ok;

   always_comb begin
      any_acq  = 1'b0;
      any_used = 1'b0;
      for (int i = 0; i < N_CONTEXT; i++) begin
         if (state_q[i] == CTX_ACQUIRED) any_acq = 1'b1;
         if (state_q[i] != CTX_FREE) any_used = 1'b1;
      end
   end

   // Only the context at pointer_q can be ACQUIRED, so commit targets it.
   assign acquire_busy_o = any_acq || (state_q[pointer_q] != CTX_FREE);
   assign grant     = acquire_req_i && !acquire_busy_o;
   assign commit_ok = commit_i && any_acq;
   assign start_ok  = !is_working_q && (state_q[running_q] == CTX_COMMITTED);
   assign done_ok   = done_i && is_working_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < N_CONTEXT; i++) begin
            state_q[i] <= CTX_FREE;
            owner_q[i] <= '0;
         end
         pointer_q     <= '0;
         running_q     <= '0;
         id_q          <= '0;
         nb_finished_q <= '0;
         is_working_q  <= 1'b0;
         start_q       <= 1'b0;
         evt_q         <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < N_CONTEXT; i++) begin
            state_q[i] <= CTX_FREE;
            owner_q[i] <= '0;
         end
         pointer_q     <= '0;
         running_q     <= '0;
         id_q          <= '0;
         nb_finished_q <= '0;
         is_working_q  <= 1'b0;
         start_q       <= 1'b0;
         evt_q         <= '0;
      end else begin
         start_q <= start_ok;
         evt_q   <= '0;
         if (grant) begin
            state_q[pointer_q] <= CTX_ACQUIRED;
            owner_q[pointer_q] <= acquire_core_i;
            id_q               <= id_q + 1'b1;
         end
         if (commit_ok) begin
            state_q[pointer_q] <= CTX_COMMITTED;
            pointer_q          <= pointer_q + 1'b1;
         end
         if (start_ok) begin
            state_q[running_q] <= CTX_RUNNING;
            is_working_q       <= 1'b1;
         end
         // Done and start are exclusive: start needs the engine idle.
         if (done_ok) begin
            state_q[running_q] <= CTX_FREE;
            running_q          <= running_q + 1'b1;
            is_working_q       <= 1'b0;
            evt_q              <= N_CORES'(1) << owner_q[running_q];
            if (nb_finished_q != '1) nb_finished_q <= nb_finished_q + 1'b1;
         end
      end
   end

   assign acquire_id_o  = id_q;
   assign start_o       = start_q;
   assign evt_o         = evt_q;
   assign pointer_ctx_o = pointer_q;
   assign running_ctx_o = running_q;
   assign is_working_o  = is_working_q;
   assign status_o      = any_used;
   assign nb_finished_o = nb_finished_q;

endmodule

// File: tb/tb_hwpe_ctrl_ctx_queue.sv
// Bench for the context queue: directed vector table, corner sequences
// and random traffic against a job-level reference model.
module tb_hwpe_ctrl_ctx_queue;

   localparam int NC  = 2;
   localparam int NCO = 4;
   localparam int IDW = 8;

   logic           clk;
   logic           rst_n;
   logic           clear;
   logic           acq_req;
   logic [1:0]     acq_core;
   logic           acq_busy;
   logic [IDW-1:0] acq_id;
   logic           commit;
   logic           start;
   logic           done;
   logic [NCO-1:0] evt;
   logic [0:0]     pointer_ctx;
   logic [0:0]     running_ctx;
   logic           is_working;
   logic           status;
   logic [IDW-1:0] nb_finished;

   hwpe_ctrl_ctx_queue #(
      .N_CONTEXT (NC),
      .N_CORES   (NCO),
      .ID_WIDTH  (IDW)
   ) dut (
      .clk_i          (clk),
      .rst_ni         (rst_n),
      .clear_i        (clear),
      .acquire_req_i  (acq_req),
      .acquire_core_i (acq_core),
      .acquire_busy_o (acq_busy),
      .acquire_id_o   (acq_id),
      .commit_i       (commit),
      .start_o        (start),
      .done_i         (done),
      .evt_o          (evt),
      .pointer_ctx_o  (pointer_ctx),
      .running_ctx_o  (running_ctx),
      .is_working_o   (is_working),
      .status_o       (status),
      .nb_finished_o  (nb_finished)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Job-level model: one pending acquisition, a FIFO of committed
   // owners, at most one running job, and plain event counters.
   bit m_acq;
   int m_acq_own;
   int m_wait[$];
   bit m_run;
   int m_run_own;
   int m_id;
   int m_nbf;
   int m_commits;
   int m_dones;
   bit m_start;
   int m_evt;

   typedef struct {
      bit a;
      int core;
      bit cm;
      bit dn;
      bit cl;
      bit e_busy;
      bit e_start;
      int e_evt;
      int e_nbf;
      int e_id;
   } vec_t;

   vec_t vecs[21];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit m_busy();
      return m_acq || ((m_wait.size() + int'(m_run)) == NC);
   endfunction

   function automatic void m_reset();
      m_acq = 0; m_acq_own = 0; m_wait.delete();
      m_run = 0; m_run_own = 0; m_id = 0; m_nbf = 0;
      m_commits = 0; m_dones = 0; m_start = 0; m_evt = 0;
   endfunction

   function automatic void m_edge(bit a, int c, bit cm, bit dn, bit cl);
      bit grant, cok, sok, dok;
      if (cl) begin
         m_reset();
         return;
      end
      grant = a && !m_busy();
      cok = cm && m_acq;
      sok = !m_run && (m_wait.size() > 0);
      dok = dn && m_run;
      m_start = sok;
      m_evt = dok ? (1 << m_run_own) : 0;
      if (dok) begin
         m_run = 0;
         if (m_nbf < 255) m_nbf++;
         m_dones++;
      end
      if (sok) begin
         m_run = 1;
         m_run_own = m_wait.pop_front();
      end
      if (cok) begin
         m_wait.push_back(m_acq_own);
         m_acq = 0;
         m_commits++;
      end
      if (grant) begin
         m_acq = 1;
         m_acq_own = c;
         m_id = (m_id + 1) % 256;
      end
   endfunction

   task automatic check_model();
      chk("busy", int'(acq_busy), int'(m_busy()));
      chk("acq_id", int'(acq_id), m_id);
      chk("start", int'(start), int'(m_start));
      chk("evt", int'(evt), m_evt);
      chk("pointer", int'(pointer_ctx), m_commits % NC);
      chk("running", int'(running_ctx), m_dones % NC);
      chk("is_working", int'(is_working), int'(m_run));
      chk("status", int'(status), int'(m_acq || m_wait.size() > 0 || m_run));
      chk("nb_finished", int'(nb_finished), m_nbf);
   endtask

   task automatic step(input bit a, input int c, input bit cm, input bit dn, input bit cl);
      @(negedge clk);
      acq_req = a; acq_core = 2'(c); commit = cm; done = dn; clear = cl;
      @(posedge clk);
      m_edge(a, c, cm, dn, cl);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      @(negedge clk);
      acq_req = 0; commit = 0; done = 0; clear = 0;
      rst_n = 1'b0;
      #2;
      m_reset();
      chk("rst_evt", int'(evt), 0);
      chk("rst_status", int'(status), 0);
      rst_n = 1'b1;
      #1;
      check_model();
   endtask

   initial begin
      // a core cm dn cl | busy start evt nbf id
      vecs[0]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      vecs[1]  = '{1, 2, 0, 0, 0, 1, 0, 0, 0, 1};
      vecs[2]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
      vecs[3]  = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
      vecs[4]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1};
      vecs[5]  = '{0, 0, 0, 1, 0, 0, 0, 4, 1, 1};
      vecs[6]  = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
      vecs[7]  = '{1, 0, 0, 0, 0, 1, 0, 0, 1, 2};
      vecs[8]  = '{1, 1, 0, 0, 0, 1, 0, 0, 1, 2};
      vecs[9]  = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 2};
      vecs[10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 2};
      vecs[11] = '{1, 1, 0, 0, 0, 1, 0, 0, 1, 3};
      vecs[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 3};
      vecs[13] = '{1, 3, 0, 0, 0, 1, 0, 0, 1, 3};
      vecs[14] = '{0, 0, 0, 1, 0, 0, 0, 1, 2, 3};
      vecs[15] = '{0, 0, 0, 0, 0, 0, 1, 0, 2, 3};
      vecs[16] = '{0, 0, 0, 1, 0, 0, 0, 2, 3, 3};
      vecs[17] = '{1, 3, 0, 0, 0, 1, 0, 0, 3, 4};
      vecs[18] = '{0, 0, 1, 1, 0, 0, 0, 0, 3, 4};
      vecs[19] = '{0, 0, 0, 0, 0, 0, 1, 0, 3, 4};
      vecs[20] = '{0, 0, 0, 1, 0, 0, 0, 8, 4, 4};

      rst_n = 1'b0; clear = 0; acq_req = 0; acq_core = 0;
      commit = 0; done = 0;
      m_reset();
      #12;
      check_model();
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].a, vecs[i].core, vecs[i].cm, vecs[i].dn, vecs[i].cl);
         chk($sformatf("vec%0d_busy", i), int'(acq_busy), int'(vecs[i].e_busy));
         chk($sformatf("vec%0d_start", i), int'(start), int'(vecs[i].e_start));
         chk($sformatf("vec%0d_evt", i), int'(evt), vecs[i].e_evt);
         chk($sformatf("vec%0d_nbf", i), int'(nb_finished), vecs[i].e_nbf);
         chk($sformatf("vec%0d_id", i), int'(acq_id), vecs[i].e_id);
      end

      // Commit and done together on a full queue; restart one cycle later.
      step(1, 1, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      step(1, 2, 0, 0, 0);
      chk("full_busy", int'(acq_busy), 1);
      step(0, 0, 1, 1, 0);
      chk("cd_evt", int'(evt), 2);
      step(0, 0, 0, 0, 0);
      chk("cd_restart", int'(start), 1);
      step(0, 0, 0, 1, 0);

      // Clear while a job runs: no completion event afterwards.
      step(1, 3, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      chk("pre_clear_working", int'(is_working), 1);
      step(1, 1, 1, 1, 1);
      chk("clear_status", int'(status), 0);
      chk("clear_working", int'(is_working), 0);
      chk("clear_evt", int'(evt), 0);
      step(0, 0, 0, 1, 0);
      chk("post_clear_evt", int'(evt), 0);

      // Reset in the middle of a job.
      step(1, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 0, 0);
      do_reset();
      step(0, 0, 0, 1, 0);
      chk("post_rst_evt", int'(evt), 0);

      // Counter wrap and saturation.
      for (int r = 0; r < 256; r++) begin
         step(1, r % 4, 0, 0, 0);
         step(0, 0, 1, 0, 0);
         step(0, 0, 0, 0, 0);
         step(0, 0, 0, 1, 0);
      end
      chk("id_wrap", int'(acq_id), 0);
      chk("nbf_sat", int'(nb_finished), 255);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 99) < 50, $urandom_range(0, 3),
              $urandom_range(0, 99) < 40, $urandom_range(0, 99) < 30,
              $urandom_range(0, 999) < 5);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
